alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-port arbiter and result-holding stage that shares one `ALU` instance between two requesters, for example the integer issue path and the branch/address-generation path. It accepts one operation per cycle from a round-robin-selected requester and runs it through the shared `ALU`. The result, flags, tag and source ID are registered into a single-entry output buffer, which the consumer drains through a valid/ready handshake.

## Interface
Parameters:
- `size`, 32, operand and result width (passed to `ALU`)
- `TAG_W`, 4, width of the opaque requester tag

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  requester 0 presents an operation
- `req0_ready`  out  1  requester 0 operation accepted this cycle
- `req0_a`, `req0_b`  in  `size`  operands
- `req0_sel`  in  3  `ALU` `Sel` code
- `req0_tag`  in  `TAG_W`  returned unchanged with the result
- `req1_*`  same set as `req0_*`, for requester 1
- `rsp_valid`  out  1  output buffer holds a result
- `rsp_ready`  in  1  consumer takes the result this cycle
- `rsp_s`  out  `size`  `ALU` result
- `rsp_flags`  out  4  {C,V,Z,N}
- `rsp_tag`  out  `TAG_W`  tag of the producing request
- `rsp_src`  out  1  0 = requester 0, 1 = requester 1

## Operation
- **State:** output buffer (`rsp_*` registers plus `rsp_valid`) and a 1-bit `last_grant` pointer.
- **Space available:** `space = !rsp_valid || rsp_ready`.
- **Grant:**
  - Only one `reqN_valid` high: that requester is granted.
  - Both high: the requester ≠ `last_grant` is granted.
  - Neither high: no grant.
- **Ready:** `reqN_ready = grantN && space && !reset`. Ready is combinational and depends only on the valids, `last_grant`, `rsp_valid` and `rsp_ready`. It never depends on operand values.
- **Transfer:** occurs when `reqN_valid && reqN_ready`. The granted operands and select drive the `ALU` combinationally. On the clock edge:
  - `rsp_s`, `rsp_flags` and `rsp_tag` capture the `ALU` result and the granted tag; `rsp_src` captures N.
  - `rsp_valid` goes to 1.
  - `last_grant` goes to N.
- **Drain only:** `rsp_valid && rsp_ready` with no transfer: `rsp_valid` goes to 0; the data registers hold.
- **Simultaneous drain and transfer:** new data replaces old, and `rsp_valid` stays 1. This gives full throughput of 1 op/cycle.
- **Backpressure:** while `rsp_valid && !rsp_ready`, both readies are 0, and the buffer and `last_grant` hold. Requesters must hold valid and payload stable until ready; the block does not buffer dropped requests.
- **`last_grant`:** changes only on a transfer. A requester that drops valid without a transfer does not move the pointer.
- **Fairness:** when both requesters stay valid and the output is always drained, grants alternate 0,1,0,1… Neither requester waits more than one transfer.

## Timing
- **Latency:** operation accepted in cycle T → `rsp_valid` = 1 with the result in cycle T+1.
- **Throughput:** one operation per cycle while `rsp_ready` = 1.
- **Reset values (asynchronous):**
  - `rsp_valid` = 0, `rsp_s` = 0, `rsp_flags` = 0, `rsp_tag` = 0, `rsp_src` = 0.
  - `last_grant` = 1, so requester 0 wins the first contested cycle.
  - `req0_ready` = `req1_ready` = 0 while `reset` is high.
- **Reset mid-operation:** a result not yet drained is discarded, not replayed. The first cycle after deassertion behaves as the first cycle out of reset.

## Structure
- **Package `alu_arb_pkg`:**
  - `alu_flags_t` packed struct {C,V,Z,N}
  - `SRC_REQ0` / `SRC_REQ1` constants
  - `ALU_SEL_W` = 3
- **Sub-module:** exactly one `ALU #(.size(size))` instance, fed by a 2:1 operand/select mux driven by the grant.
- **In-block logic:** the round-robin grant is small enough to remain inline; no separate arbiter module.

## Test plan
- **Reset:** assert `reset` mid-cycle with `rsp_valid` = 1 → outputs go to 0 immediately and readies go to 0. After release, requester 0 alone (A=5, B=3, tag=2) → `rsp_valid` at T+1, `rsp_tag` = 2, `rsp_src` = 0, `rsp_s` equals the `ALU` model.
- **Contention:** both valid every cycle, `rsp_ready` = 1, tags 0x1 on requester 0 and 0xA on requester 1, for 6 cycles → `rsp_src` sequence 0,1,0,1,0,1 and one result per cycle.
- **Backpressure:** `rsp_ready` = 0 for 3 cycles with the buffer full → both readies stay 0 and the `rsp_*` outputs are stable. Raise `rsp_ready` → the next transfer happens in the same cycle as the drain, and `rsp_valid` stays 1.
- **Pointer hold:** requester 1 wins; requester 0 then alone for 2 ops; then both valid → requester 1 is granted, because `last_grant` = 0.
- **Random:** 10k cycles with random valids, operands, `Sel`, `rsp_ready`, and requester payloads held stable until accepted → every accepted op appears exactly once, in order, with matching tag, src, `rsp_s` and flags versus the scoreboard. No requester waits more than 2 cycles while the output drains.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester shared-ALU arbiter.
package alu_arb_pkg;

   localparam int unsigned ALU_SEL_W = 3;

   typedef struct packed {
      logic c;
      logic v;
      logic z;
      logic n;
   } alu_flags_t;

   localparam logic SRC_REQ0 = 1'b0;
   localparam logic SRC_REQ1 = 1'b1;

   typedef enum logic [ALU_SEL_W-1:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_NOT = 3'd5,
      ALU_SHL = 3'd6,
      ALU_SHR = 3'd7
   } alu_op_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester/consumer bundle for alu_share_arb; master = requesters and consumer, slave = arbiter.
interface alu_share_arb_if
   import alu_arb_pkg::*;
#(
   parameter int unsigned size  = 32,
   parameter int unsigned TAG_W = 4
);
   logic                 req0_valid;
   logic                 req0_ready;
   logic [size-1:0]      req0_a;
   logic [size-1:0]      req0_b;
   logic [ALU_SEL_W-1:0] req0_sel;
   logic [TAG_W-1:0]     req0_tag;

   logic                 req1_valid;
   logic                 req1_ready;
   logic [size-1:0]      req1_a;
   logic [size-1:0]      req1_b;
   logic [ALU_SEL_W-1:0] req1_sel;
   logic [TAG_W-1:0]     req1_tag;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [size-1:0]      rsp_s;
   alu_flags_t           rsp_flags;
   logic [TAG_W-1:0]     rsp_tag;
   logic                 rsp_src;

   modport master (
      output req0_valid, req0_a, req0_b, req0_sel, req0_tag,
      output req1_valid, req1_a, req1_b, req1_sel, req1_tag,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_s, rsp_flags, rsp_tag, rsp_src
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sel, req0_tag,
      input  req1_valid, req1_a, req1_b, req1_sel, req1_tag,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_s, rsp_flags, rsp_tag, rsp_src
   );
endinterface

// File: rtl/ALU.sv
// Combinational ALU: add/sub/logic/shift-by-one with {C,V,Z,N} flags.
module ALU
   import alu_arb_pkg::*;
#(
   parameter int unsigned size = 32
) (
   input  logic [size-1:0]      a_i,
   input  logic [size-1:0]      b_i,
   input  logic [ALU_SEL_W-1:0] sel_i,
   output logic [size-1:0]      s_o,
   output alu_flags_t           flags_o
);
   logic [size:0] sum_c;

   always_comb begin
      sum_c   = '0;
      s_o     = '0;
      flags_o = '0;
      case (alu_op_e'(sel_i))
         ALU_ADD: begin
            sum_c     = {1'b0, a_i} + {1'b0, b_i};
            s_o       = sum_c[size-1:0];
            flags_o.c = sum_c[size];
            flags_o.v = (a_i[size-1] == b_i[size-1]) && (s_o[size-1] != a_i[size-1]);
         end
         // C is the no-borrow carry of a + ~b + 1
         ALU_SUB: begin
            sum_c     = {1'b0, a_i} + {1'b0, ~b_i} + (size+1)'(1);
            s_o       = sum_c[size-1:0];
            flags_o.c = sum_c[size];
            flags_o.v = (a_i[size-1] != b_i[size-1]) && (s_o[size-1] != a_i[size-1]);
         end
         ALU_AND: s_o = a_i & b_i;
         ALU_OR:  s_o = a_i | b_i;
         ALU_XOR: s_o = a_i ^ b_i;
         ALU_NOT: s_o = ~a_i;
         ALU_SHL: begin
            s_o       = {a_i[size-2:0], 1'b0};
            flags_o.c = a_i[size-1];
         end
         ALU_SHR: begin
            s_o       = {1'b0, a_i[size-1:1]};
            flags_o.c = a_i[0];
         end
         default: ;
      endcase
      flags_o.z = (s_o == '0);
      flags_o.n = s_o[size-1];
   end
endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between two requesters, with a single-entry
// registered result buffer drained by valid/ready.
module alu_share_arb
   import alu_arb_pkg::*;
#(
   parameter int unsigned size  = 32,
   parameter int unsigned TAG_W = 4
) (
   input  logic           clk,
   input  logic           reset,
   alu_share_arb_if.slave bus
);
   logic             last_grant_q, last_grant_d;
   logic             rsp_valid_q,  rsp_valid_d;
   logic [size-1:0]  rsp_s_q,      rsp_s_d;
   alu_flags_t       rsp_flags_q,  rsp_flags_d;
   logic [TAG_W-1:0] rsp_tag_q,    rsp_tag_d;
   logic             rsp_src_q,    rsp_src_d;

   logic                 gnt1_c, space_c, rdy0_c, rdy1_c, xfer_c;
   logic [size-1:0]      op_a_c, op_b_c, alu_s_c;
   logic [ALU_SEL_W-1:0] op_sel_c;
   logic [TAG_W-1:0]     op_tag_c;
   alu_flags_t           alu_flags_c;

   // Grant, readiness and operand mux; readies never look at payload.
   always_comb begin
      gnt1_c   = bus.req1_valid && (!bus.req0_valid || (last_grant_q == SRC_REQ0));
      space_c  = !rsp_valid_q || bus.rsp_ready;
      rdy0_c   = bus.req0_valid && !gnt1_c && space_c && !reset;
      rdy1_c   = bus.req1_valid &&  gnt1_c && space_c && !reset;
      xfer_c   = rdy0_c || rdy1_c;
      op_a_c   = gnt1_c ? bus.req1_a   : bus.req0_a;
      op_b_c   = gnt1_c ? bus.req1_b   : bus.req0_b;
      op_sel_c = gnt1_c ? bus.req1_sel : bus.req0_sel;
      op_tag_c = gnt1_c ? bus.req1_tag : bus.req0_tag;
   end

   ALU #(.size(size)) u_alu (
      .a_i     (op_a_c),
      .b_i     (op_b_c),
      .sel_i   (op_sel_c),
      .s_o     (alu_s_c),
      .flags_o (alu_flags_c)
   );

   // Next state: a transfer overwrites the buffer even while it drains.
   always_comb begin
      last_grant_d = last_grant_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_s_d      = rsp_s_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_src_d    = rsp_src_q;
      if (xfer_c) begin
         rsp_valid_d  = 1'b1;
         rsp_s_d      = alu_s_c;
         rsp_flags_d  = alu_flags_c;
         rsp_tag_d    = op_tag_c;
         rsp_src_d    = gnt1_c ? SRC_REQ1 : SRC_REQ0;
         last_grant_d = gnt1_c ? SRC_REQ1 : SRC_REQ0;
      end else if (bus.rsp_ready) begin
         rsp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_q <= SRC_REQ1;
         rsp_valid_q  <= 1'b0;
         rsp_s_q      <= '0;
         rsp_flags_q  <= '0;
         rsp_tag_q    <= '0;
         rsp_src_q    <= SRC_REQ0;
      end else begin
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_s_q      <= rsp_s_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_src_q    <= rsp_src_d;
      end
   end

   assign bus.req0_ready = rdy0_c;
   assign bus.req1_ready = rdy1_c;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_s      = rsp_s_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_tag    = rsp_tag_q;
   assign bus.rsp_src    = rsp_src_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: directed reset/contention/backpressure/pointer
// cases followed by a long random run against a reference ALU and arbiter model.
module tb_alu_share_arb;
   import alu_arb_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned TW = 4;

   typedef struct packed {
      logic [W-1:0]  s;
      logic [3:0]    f;
      logic [TW-1:0] tag;
      logic          src;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_share_arb_if #(.size(W), .TAG_W(TW)) bus ();
   alu_share_arb #(.size(W), .TAG_W(TW)) dut (.clk(clk), .reset(reset), .bus(bus));

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   exp_t        exp_q[$];
   logic        m_valid = 1'b0;
   logic        m_last  = 1'b1;
   logic        acc0 = 1'b0, acc1 = 1'b0;
   int unsigned w0 = 0, w1 = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference ALU written from signed/unsigned arithmetic; returns {C,V,Z,N,s}.
   function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] sel);
      logic [31:0] s;
      logic        c, v;
      longint      r;
      c = 1'b0; v = 1'b0; s = '0;
      case (sel)
         3'd0: begin
            s = a + b; c = (s < a);
            r = longint'($signed(a)) + longint'($signed(b));
            v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         3'd1: begin
            s = a - b; c = (a >= b);
            r = longint'($signed(a)) - longint'($signed(b));
            v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         3'd2: s = a & b;
         3'd3: s = a | b;
         3'd4: s = a ^ b;
         3'd5: s = ~a;
         3'd6: begin s = a << 1; c = a[31]; end
         default: begin s = a >> 1; c = a[0]; end
      endcase
      return {c, v, (s == 32'd0), s[31], s};
   endfunction

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic set_req(input int n, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] sel, input logic [3:0] tag);
      if (n == 0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel; bus.req0_tag = tag;
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel; bus.req1_tag = tag;
      end
   endtask

   task automatic chk_rsp(input string tag, input logic src, input logic [3:0] etag,
                          input logic [35:0] r);
      chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'(1));
      chk({tag, "_src"},   64'(bus.rsp_src),   64'(src));
      chk({tag, "_tag"},   64'(bus.rsp_tag),   64'(etag));
      chk({tag, "_s"},     64'(bus.rsp_s),     64'(r[31:0]));
      chk({tag, "_flags"}, 64'(bus.rsp_flags), 64'(r[35:32]));
   endtask

   // Model reset: any queued result is discarded, pointer back to requester 1.
   always @(posedge reset) begin
      exp_q.delete();
      m_valid = 1'b0; m_last = 1'b1;
      acc0 = 1'b0; acc1 = 1'b0; w0 = 0; w1 = 0;
   end

   // Monitor on the falling edge: check readies/valid, pop on drain, push on transfer.
   always @(negedge clk) begin
      logic        sp, g1, e0, e1;
      logic [35:0] r;
      exp_t        e;
      if (!reset) begin
         sp = !m_valid || bus.rsp_ready;
         g1 = bus.req1_valid && (!bus.req0_valid || !m_last);
         e0 = bus.req0_valid && !g1 && sp;
         e1 = bus.req1_valid &&  g1 && sp;
         chk("req0_ready", 64'(bus.req0_ready), 64'(e0));
         chk("req1_ready", 64'(bus.req1_ready), 64'(e1));
         chk("rsp_valid",  64'(bus.rsp_valid),  64'(m_valid));
         if (m_valid && bus.rsp_ready) begin
            chk("sb_depth", 64'(exp_q.size()), 64'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sb_s",     64'(bus.rsp_s),     64'(e.s));
               chk("sb_flags", 64'(bus.rsp_flags), 64'(e.f));
               chk("sb_tag",   64'(bus.rsp_tag),   64'(e.tag));
               chk("sb_src",   64'(bus.rsp_src),   64'(e.src));
            end
         end
         acc0 = bus.req0_valid && bus.req0_ready;
         acc1 = bus.req1_valid && bus.req1_ready;
         if (bus.req0_valid && !bus.req0_ready && bus.rsp_ready) w0++;
         if (bus.req1_valid && !bus.req1_ready && bus.rsp_ready) w1++;
         if (acc0) begin chk("wait0", 64'(w0 > 2), 64'(0)); w0 = 0; end
         if (acc1) begin chk("wait1", 64'(w1 > 2), 64'(0)); w1 = 0; end
         if (!bus.req0_valid) w0 = 0;
         if (!bus.req1_valid) w1 = 0;
         if (e0 || e1) begin
            r = e1 ? alu_ref(bus.req1_a, bus.req1_b, bus.req1_sel)
                   : alu_ref(bus.req0_a, bus.req0_b, bus.req0_sel);
            e.s   = r[31:0];
            e.f   = r[35:32];
            e.tag = e1 ? bus.req1_tag : bus.req0_tag;
            e.src = e1;
            exp_q.push_back(e);
            m_valid = 1'b1;
            m_last  = e1;
         end else if (bus.rsp_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   initial begin
      logic [35:0] r0, r1;
      reset = 1'b1;
      set_req(0, 1'b1, 32'd1, 32'd1, 3'd0, 4'h7);
      set_req(1, 1'b0, 32'd0, 32'd0, 3'd0, 4'h0);
      bus.rsp_ready = 1'b0;

      // Reset values, then a result left undrained and killed by a mid-cycle reset.
      @(posedge clk); #3;
      chk("rst0_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst0_ready", 64'(bus.req0_ready), 64'(0));
      reset = 1'b0;
      @(posedge clk); #1;
      chk("pre_valid", 64'(bus.rsp_valid), 64'(1));
      bus.req0_valid = 1'b0;
      #3 reset = 1'b1;
      #1;
      chk("rst_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_s",     64'(bus.rsp_s),     64'(0));
      chk("rst_flags", 64'(bus.rsp_flags), 64'(0));
      chk("rst_tag",   64'(bus.rsp_tag),   64'(0));
      chk("rst_src",   64'(bus.rsp_src),   64'(0));
      set_req(0, 1'b1, 32'd5, 32'd3, 3'd0, 4'h2);
      bus.rsp_ready = 1'b1;
      #1;
      chk("rst_ready0", 64'(bus.req0_ready), 64'(0));
      @(posedge clk); #3 reset = 1'b0;
      @(posedge clk); #1;
      chk_rsp("first", 1'b0, 4'h2, alu_ref(32'd5, 32'd3, 3'd0));
      bus.req0_valid = 1'b0;

      // Contention from a fresh reset: grants alternate starting with requester 0.
      @(posedge clk); #2 reset = 1'b1;
      @(posedge clk); #2 reset = 1'b0;
      set_req(0, 1'b1, 32'h0000_0010, 32'h0000_0013, 3'd1, 4'h1);
      set_req(1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 3'd0, 4'hA);
      r0 = alu_ref(32'h0000_0010, 32'h0000_0013, 3'd1);
      r1 = alu_ref(32'h7FFF_FFFF, 32'h0000_0001, 3'd0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (i % 2 == 0) chk_rsp("cont", 1'b0, 4'h1, r0);
         else            chk_rsp("cont", 1'b1, 4'hA, r1);
      end

      // Backpressure: buffer full and stalled, then drain and refill in one cycle.
      bus.rsp_ready = 1'b0;
      #1;
      chk("bp_rdy0", 64'(bus.req0_ready), 64'(0));
      chk("bp_rdy1", 64'(bus.req1_ready), 64'(0));
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk_rsp("bp_hold", 1'b1, 4'hA, r1);
         chk("bp_hold_rdy0", 64'(bus.req0_ready), 64'(0));
         chk("bp_hold_rdy1", 64'(bus.req1_ready), 64'(0));
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_rel_rdy0", 64'(bus.req0_ready), 64'(1));
      chk("bp_rel_rdy1", 64'(bus.req1_ready), 64'(0));
      @(posedge clk); #1;
      chk_rsp("bp_refill", 1'b0, 4'h1, r0);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

      // Pointer hold: 1 wins, 0 alone twice, then contested goes to 1.
      @(posedge clk); #1;
      set_req(1, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'd3, 4'h5);
      @(posedge clk); #1;
      chk_rsp("ptr_r1", 1'b1, 4'h5, alu_ref(32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'd3));
      bus.req1_valid = 1'b0;
      set_req(0, 1'b1, 32'h8000_0001, 32'd0, 3'd6, 4'h3);
      @(posedge clk); #1;
      chk_rsp("ptr_r0a", 1'b0, 4'h3, alu_ref(32'h8000_0001, 32'd0, 3'd6));
      set_req(0, 1'b1, 32'h0000_0001, 32'd0, 3'd7, 4'h4);
      @(posedge clk); #1;
      chk_rsp("ptr_r0b", 1'b0, 4'h4, alu_ref(32'h0000_0001, 32'd0, 3'd7));
      set_req(0, 1'b1, 32'h1234_5678, 32'h1234_5678, 3'd4, 4'h6);
      set_req(1, 1'b1, 32'h0000_0000, 32'd0, 3'd5, 4'h9);
      #1;
      chk("ptr_rdy1", 64'(bus.req1_ready), 64'(1));
      chk("ptr_rdy0", 64'(bus.req0_ready), 64'(0));
      @(posedge clk); #1;
      chk_rsp("ptr_both", 1'b1, 4'h9, alu_ref(32'h0000_0000, 32'd0, 3'd5));
      bus.req1_valid = 1'b0;
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;

      // Random traffic; payloads only change after acceptance.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(posedge clk); #1;
         if (!bus.req0_valid || acc0)
            set_req(0, ($urandom_range(0, 9) < 6), rnd_word(), rnd_word(),
                    3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         if (!bus.req1_valid || acc1)
            set_req(1, ($urandom_range(0, 9) < 6), rnd_word(), rnd_word(),
                    3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         bus.rsp_ready = ($urandom_range(0, 9) < 7);
      end
      @(posedge clk); #1;
      if (acc0) bus.req0_valid = 1'b0;
      if (acc1) bus.req1_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (acc0) bus.req0_valid = 1'b0;
         if (acc1) bus.req1_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("sb_drained", 64'(exp_q.size()), 64'(0));
      chk("end_valid",  64'(bus.rsp_valid), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
